vga_output_stage: RTL and testbench

Downstream consumer of the brighten filter stage: accepts the filtered 8-bit greyscale pixel stream over a valid/ready handshake and buffers it in a small FIFO. It runs the 640x480 VGA timing counters, pops one pixel per active-region clock, and drives registered greyscale RGB, sync and blank outputs. A start-of-frame tag aligns the stream to the raster, with explicit underflow and resync handling.

---
 rtl/vga_output_stage.sv | 218 +++++++++++++++++++++
 tb/tb_vga_output_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_output_stage.sv
// rtl/vga_output_stage.sv - FIFO-buffered greyscale pixel stream to 640x480 VGA raster with sof alignment
// Optional build macro: VGA_UNDERFLOW_HOLD_EN (repeat the last displayed pixel on underflow instead of black)
module vga_output_stage #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pixel_in,
   input  logic       pixel_sof,
   input  logic       pixel_valid,
   output logic       pixel_ready,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic       underflow,
   output logic       sync_err
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CW      = AW + 1;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);

   typedef enum logic {SYNC_WAIT, STREAM} state_t;

   state_t          state, next_state;
   logic [HW-1:0]   h_cnt;
   logic [VW-1:0]   v_cnt;
   logic            active;
   logic            at_origin;
   logic            h_in_sync;
   logic            v_in_sync;

   logic [8:0]      fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            fifo_empty;
   logic            fifo_full;
   logic            push;
   logic            pop;
   logic [8:0]      head;
   logic            head_sof;
   logic [7:0]      head_pix;

   logic [7:0]      disp_pix;
   logic [7:0]      uf_pix;
   logic            uf_next;
   logic            se_next;

   assign active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
   assign at_origin = (h_cnt == '0) && (v_cnt == '0);
   assign h_in_sync = (h_cnt >= HS_START) && (h_cnt < HS_END);
   assign v_in_sync = (v_cnt >= VS_START) && (v_cnt < VS_END);

   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == FIFO_FULL);
   assign pixel_ready = !fifo_full;
   assign push        = pixel_valid && !fifo_full;
   assign head        = fifo_mem[rd_ptr];
   assign head_sof    = head[8];
   assign head_pix    = head[7:0];

   // Raster counters: h wraps each line, v advances on the h wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {pixel_sof, pixel_in};
      end
   end

   // FIFO pointers and occupancy; pop decisions only ever see registered count
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

`ifdef VGA_UNDERFLOW_HOLD_EN
   logic       show;
   logic [7:0] last_pix;

   // A pop is displayed in STREAM, or in SYNC_WAIT only when it is the sof entry taken at the origin
   assign show = pop && ((state == STREAM) || head_sof);

   // Remember the last pixel actually put on screen for underflow repeats
   always_ff @(posedge clk) begin
      if (reset) begin
         last_pix <= 8'h00;
      end else if (show) begin
         last_pix <= head_pix;
      end
   end

   assign uf_pix = last_pix;
`else
   assign uf_pix = 8'h00;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SYNC_WAIT;
      end else begin
         state <= next_state;
      end
   end

   // FSM next state, pop decision and the pixel to display this cycle
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      disp_pix   = 8'h00;
      uf_next    = 1'b0;
      se_next    = 1'b0;
      case (state)
         SYNC_WAIT: begin
            if (!fifo_empty) begin
               if (!head_sof) begin
                  pop = 1'b1;
               end else if (at_origin) begin
                  pop        = 1'b1;
                  disp_pix   = head_pix;
                  next_state = STREAM;
               end
            end
         end
         STREAM: begin
            if (active) begin
               if (fifo_empty) begin
                  uf_next  = 1'b1;
                  disp_pix = uf_pix;
               end else if (head_sof == at_origin) begin
                  pop      = 1'b1;
                  disp_pix = head_pix;
               end else begin
                  se_next    = 1'b1;
                  next_state = SYNC_WAIT;
               end
            end
         end
         default: next_state = SYNC_WAIT;
      endcase
   end

   // Registered video, sync and status outputs, all one cycle behind the counters
   always_ff @(posedge clk) begin
      if (reset) begin
         vga_r       <= 8'h00;
         vga_g       <= 8'h00;
         vga_b       <= 8'h00;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         underflow   <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         vga_r       <= disp_pix;
         vga_g       <= disp_pix;
         vga_b       <= disp_pix;
         vga_hs      <= !h_in_sync;
         vga_vs      <= !v_in_sync;
         vga_blank_n <= active;
         underflow   <= uf_next;
         sync_err    <= se_next;
      end
   end

endmodule

// File: tb/tb_vga_output_stage.sv
// tb/tb_vga_output_stage.sv - directed self-checking bench for vga_output_stage on a reduced raster
module tb_vga_output_stage;

   localparam int HA    = 16;
   localparam int HFP   = 2;
   localparam int HS    = 4;
   localparam int HBP   = 3;
   localparam int VA    = 6;
   localparam int VFP   = 1;
   localparam int VS    = 2;
   localparam int VBP   = 2;
   localparam int DEPTH = 8;
   localparam int HT    = HA + HFP + HS + HBP;
   localparam int VT    = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
`ifdef VGA_UNDERFLOW_HOLD_EN
   localparam int UF_VAL = 8'h5A;
`else
   localparam int UF_VAL = 0;
`endif

   logic       clk;
   logic       reset;
   logic [7:0] pixel_in;
   logic       pixel_sof;
   logic       pixel_valid;
   logic       pixel_ready;
   logic [7:0] vga_r;
   logic [7:0] vga_g;
   logic [7:0] vga_b;
   logic       vga_hs;
   logic       vga_vs;
   logic       vga_blank_n;
   logic       underflow;
   logic       sync_err;

   vga_output_stage #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .pixel_in(pixel_in), .pixel_sof(pixel_sof), .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .underflow(underflow), .sync_err(sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   int         mh = 0, mv = 0, mf = 0;
   int         oh = 0, ov = 0, of = 0;
   int         n_acc = 0;
   bit         pend = 1'b0;
   logic [8:0] q[$];

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit act(input int h, input int v);
      return (h < HA) && (v < VA);
   endfunction

   // One clock: outputs seen at this negedge belong to raster position (oh,ov) of frame of
   task automatic step();
      @(negedge clk);
      oh = mh; ov = mv; of = mf;
      if (reset) begin
         mh = 0; mv = 0; mf = 0;
      end else if (mh == HT - 1) begin
         mh = 0;
         if (mv == VT - 1) begin
            mv = 0;
            mf++;
         end else begin
            mv++;
         end
      end else begin
         mh++;
      end
      if (pend && !reset) begin
         void'(q.pop_front());
         n_acc++;
      end
      if (q.size() > 0) begin
         pixel_valid = 1'b1;
         {pixel_sof, pixel_in} = q[0];
      end else begin
         pixel_valid = 1'b0;
         pixel_sof   = 1'b0;
         pixel_in    = 8'h00;
      end
      pend = pixel_valid && pixel_ready;
   endtask

   task automatic push_frame(input int off, input int first, input int n);
      for (int i = 0; i < n; i++) begin
         int val;
         val = (i == 0 && first >= 0) ? first : (((i % HA) + (i / HA) + off) & 255);
         q.push_back({1'(i == 0), 8'(val)});
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      q.delete();
      pend        = 1'b0;
      pixel_valid = 1'b0;
      pixel_sof   = 1'b0;
      pixel_in    = 8'h00;
      step();
      step();
      reset = 1'b0;
      n_acc = 0;
   endtask

   initial begin
      int e, pix_bad, tim_bad, line_bad, hs_line, bl_line, vs_cyc, uf_cnt, se_cnt;
      int found, uf_bad, hold_bad, uf_n, got, ee, blk_bad, nz, bad2, uf2;
      int first_hs, r7, r8;

      reset = 1'b1;
      pixel_valid = 1'b0;
      pixel_sof = 1'b0;
      pixel_in = 8'h00;

      // reset state
      step();
      step();
      check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
      check("rst_hs", vga_hs, 1);
      check("rst_vs", vga_vs, 1);
      check("rst_blank", vga_blank_n, 0);
      check("rst_uf", underflow, 0);
      check("rst_se", sync_err, 0);
      reset = 1'b0;
      check("rst_ready", pixel_ready, 1);

      // two tagged frames, valid held high; FIFO full in vblank
      push_frame(0, -1, HA * VA);
      push_frame(64, -1, HA * VA);
      pix_bad = 0; tim_bad = 0; line_bad = 0; hs_line = 0; bl_line = 0;
      vs_cyc = 0; uf_cnt = 0; se_cnt = 0;
      repeat (3 * FRAME) begin
         step();
         if (of >= 1) begin
            if (act(oh, ov)) begin
               e = (oh + ov + (of == 2 ? 64 : 0)) & 255;
               if (vga_r != e || vga_g != e || vga_b != e) pix_bad++;
            end else if (vga_r != 0) begin
               pix_bad++;
            end
            if (vga_hs != !(oh >= HA + HFP && oh < HA + HFP + HS)) tim_bad++;
            if (vga_vs != !(ov >= VA + VFP && ov < VA + VFP + VS)) tim_bad++;
            if (vga_blank_n != act(oh, ov)) tim_bad++;
            hs_line += int'(!vga_hs);
            bl_line += int'(vga_blank_n);
            vs_cyc  += int'(!vga_vs);
            if (oh == HT - 1) begin
               if (hs_line != HS || bl_line != (ov < VA ? HA : 0)) line_bad++;
               hs_line = 0;
               bl_line = 0;
            end
            uf_cnt += int'(underflow);
            se_cnt += int'(sync_err);
            if (of == 1 && oh == 3 && ov == 2) check("f1_pix_3_2", vga_r, 5);
            if (of == 2 && oh == 0 && ov == 0) check("f2_origin", vga_r, 64);
         end
         if (ov == VA + 1 && oh == 5 && of == 0) check("full_vblank0", pixel_ready, 0);
         if (ov == VA + 1 && oh == 5 && of == 1) check("full_vblank1", pixel_ready, 0);
      end
      check("frame_pix", pix_bad, 0);
      check("frame_timing", tim_bad, 0);
      check("line_counts", line_bad, 0);
      check("vs_cycles", vs_cyc, 2 * VS * HT);
      check("frame_uf", uf_cnt, 0);
      check("frame_se", se_cnt, 0);

      // upstream stall after pixel 0x5A
      do_reset();
      for (int i = 0; i < 2 * HA + 6; i++) begin
         q.push_back({1'(i == 0), (i == 2 * HA + 5) ? 8'h5A : 8'(i + 1)});
      end
      found = 0;
      for (int k = 0; k < 2 * FRAME && found == 0; k++) begin
         step();
         if (of == 1 && oh == 5 && ov == 2) begin
            found = 1;
            check("pre_stall_pix", vga_r, 8'h5A);
            check("pre_stall_uf", underflow, 0);
         end
      end
      check("stall_reach", found, 1);
      uf_bad = 0; hold_bad = 0; uf_n = 0;
      repeat (20) begin
         step();
         if (underflow != act(oh, ov)) uf_bad++;
         if (vga_r != (act(oh, ov) ? UF_VAL : 0)) hold_bad++;
         uf_n += int'(underflow);
      end
      check("stall_uf", uf_bad, 0);
      check("stall_pix", hold_bad, 0);
      check("stall_uf_n", uf_n, 11);
      q.push_back({1'b0, 8'h33});
      got = 0;
      repeat (30) begin
         step();
         if (vga_r == 8'h33 && got == 0) begin
            got = 1;
            check("resume_uf", underflow, 0);
         end
      end
      check("resume", got, 1);

      // untagged pixels ahead of a tagged frame are discarded
      do_reset();
      for (int i = 0; i < 5; i++) q.push_back({1'b0, 8'hEE});
      push_frame(0, 8'h77, HA * VA);
      se_cnt = 0; ee = 0; blk_bad = 0;
      repeat (2 * FRAME) begin
         step();
         se_cnt += int'(sync_err);
         if (vga_r == 8'hEE) ee++;
         if (of == 0 && vga_r != 0) blk_bad++;
         if (of == 1 && oh == 0 && ov == 0) check("tag_first", vga_r, 8'h77);
         if (of == 1 && oh == 1 && ov == 0) check("tag_second", vga_r, 1);
         if (of == 1 && oh == 15 && ov == 5) check("tag_last", vga_r, 20);
      end
      check("discard_se", se_cnt, 0);
      check("discard_ee", ee, 0);
      check("syncwait_black", blk_bad, 0);

      // sof injected at pixel 10 of line 3
      do_reset();
      push_frame(0, -1, 3 * HA + 10);
      push_frame(64, -1, HA * VA);
      se_cnt = 0; nz = 0; bad2 = 0; uf2 = 0;
      repeat (3 * FRAME) begin
         step();
         se_cnt += int'(sync_err);
         if (of == 1) begin
            if (oh == 9 && ov == 3) check("pre_err_pix", vga_r, 12);
            if (oh == 10 && ov == 3) begin
               check("sync_err_pulse", sync_err, 1);
               check("err_black", vga_r, 0);
            end
            if (ov > 3 || (ov == 3 && oh >= 10)) nz += int'(vga_r != 0);
         end
         if (of == 2) begin
            if (act(oh, ov) && vga_r != ((oh + ov + 64) & 255)) bad2++;
            uf2 += int'(underflow);
         end
      end
      check("sync_err_once", se_cnt, 1);
      check("err_rest_black", nz, 0);
      check("resync_frame", bad2, 0);
      check("resync_uf", uf2, 0);

      // reset mid-line, then FIFO must start empty
      do_reset();
      push_frame(0, -1, HA * VA);
      found = 0;
      for (int k = 0; k < 2 * FRAME && found == 0; k++) begin
         step();
         if (of == 1 && oh == 7 && ov == 2) found = 1;
      end
      check("midrst_reach", found, 1);
      check("midrst_pre_blank", vga_blank_n, 1);
      reset = 1'b1;
      q.delete();
      pend = 1'b0;
      pixel_valid = 1'b0;
      step();
      check("midrst_rgb", {vga_r, vga_g, vga_b}, 0);
      check("midrst_hs", vga_hs, 1);
      check("midrst_vs", vga_vs, 1);
      check("midrst_blank", vga_blank_n, 0);
      check("midrst_uf", underflow, 0);
      check("midrst_se", sync_err, 0);
      check("midrst_ready", pixel_ready, 1);
      reset = 1'b0;
      n_acc = 0;
      for (int i = 0; i < DEPTH; i++) q.push_back({1'b1, 8'h11});
      first_hs = -1; r7 = -1; r8 = -1;
      for (int k = 1; k <= HT; k++) begin
         step();
         if (!vga_hs && first_hs < 0) first_hs = k;
         if (n_acc == DEPTH - 1 && r7 < 0) r7 = int'(pixel_ready);
         if (n_acc == DEPTH && r8 < 0) r8 = int'(pixel_ready);
      end
      check("midrst_hs_pos", first_hs, HA + HFP + 1);
      check("ready_depth_m1", r7, 1);
      check("ready_depth", r8, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
